// File: rtl/conware_pkg.sv
// Shared definitions for the conware pipeline front end and output serializer.
// Frame geometry helpers and the loader state encoding live here.
package conware_pkg;

    // Number of pixels in a WIDTH x HEIGHT frame.
    function automatic int npix(input int w, input int h);
        return w * h;
    endfunction

    // Index width able to address every pixel; at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } loader_state_t;

endpackage

// File: rtl/frame_pix_counter.sv
// Pixel index register with clear, enable and a last-pixel flag.
// Wraps explicitly to zero after N-1 so the index never leaves 0..N-1.
module frame_pix_counter #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         at_last
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign at_last = (idx == LAST);

    // Clear wins over enable; enable at the last pixel wraps to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            if (at_last) begin
                idx <= '0;
            end else begin
                idx <= idx + W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_frame_loader.sv
// AXI4-Stream slave that captures one frame into a flat register buffer.
// Frame length is checked against TLAST; the buffer is held until acked.
module axis_frame_loader
    import conware_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int WIDTH  = 32,
    parameter  int HEIGHT = 32,
    localparam int NPIX   = npix(WIDTH, HEIGHT),
    localparam int IDX_W  = idx_w(NPIX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    input  logic [DWIDTH-1:0]      S_AXIS_TDATA,
    input  logic                   S_AXIS_TLAST,
    output logic [DWIDTH*NPIX-1:0] data,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic                   err_short,
    output logic                   err_long
);

    loader_state_t state;
    loader_state_t state_nx;

    logic                   ready_q;
    logic                   valid_q;
    logic                   es_q;
    logic                   el_q;
    logic                   es_nx;
    logic                   el_nx;
    logic                   acc;
    logic                   fill_acc;
    logic                   cnt_clr;
    logic                   at_last;
    logic [IDX_W-1:0]       idx;
    logic [NPIX-1:0]        we;
    logic [DWIDTH*NPIX-1:0] buf_q;

    assign acc      = S_AXIS_TVALID & ready_q;
    assign fill_acc = acc & (state == FILL);
    assign cnt_clr  = fill_acc & S_AXIS_TLAST & ~at_last;

    frame_pix_counter #(
        .N (NPIX),
        .W (IDX_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (fill_acc),
        .idx     (idx),
        .at_last (at_last)
    );

    for (genvar i = 0; i < NPIX; i++) begin : g_we
        assign we[i] = fill_acc && (idx == IDX_W'(i));
    end

    // Next state and error pulses from the current state and handshake.
    always_comb begin
        state_nx = state;
        es_nx    = 1'b0;
        el_nx    = 1'b0;
        unique case (state)
            FILL: begin
                if (acc) begin
                    if (at_last) begin
                        if (S_AXIS_TLAST) begin
                            state_nx = HOLD;
                        end else begin
                            state_nx = DRAIN;
                            el_nx    = 1'b1;
                        end
                    end else if (S_AXIS_TLAST) begin
                        es_nx = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (acc && S_AXIS_TLAST) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_nx = FILL;
                end
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Registered handshake and status outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            es_q    <= 1'b0;
            el_q    <= 1'b0;
        end else begin
            ready_q <= (state_nx != HOLD);
            valid_q <= (state_nx == HOLD);
            es_q    <= es_nx;
            el_q    <= el_nx;
        end
    end

    // Frame buffer: one word written per accepted FILL beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                if (we[i]) begin
                    buf_q[i*DWIDTH +: DWIDTH] <= S_AXIS_TDATA;
                end
            end
        end
    end

    assign S_AXIS_TREADY = ready_q;
    assign frame_valid   = valid_q;
    assign err_short     = es_q;
    assign err_long      = el_q;
    assign data          = buf_q;

endmodule

// File: tb/tb_axis_frame_loader.sv
// Bench for axis_frame_loader: directed scenarios plus random frames,
// checked every cycle against a frame-level queue model.
module tb_axis_frame_loader;

    localparam int DW   = 32;
    localparam int NPIX = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tvalid = 1'b0;
    logic              tready;
    logic [DW-1:0]     tdata = '0;
    logic              tlast = 1'b0;
    logic [DW*NPIX-1:0] data;
    logic              fvalid;
    logic              ack = 1'b0;
    logic              es;
    logic              el;

    int total = 0;
    int bad   = 0;
    int n_es  = 0;
    int n_el  = 0;
    bit chk_en = 1'b0;

    bit            m_ready = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_es = 1'b0;
    bit            m_el = 1'b0;
    bit            m_acc = 1'b0;
    bit            dropping = 1'b0;
    logic [DW-1:0] cur[$];
    logic [DW-1:0] exp_buf[NPIX];

    axis_frame_loader #(
        .DWIDTH (DW),
        .WIDTH  (4),
        .HEIGHT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TLAST  (tlast),
        .data          (data),
        .frame_valid   (fvalid),
        .frame_ack     (ack),
        .err_short     (es),
        .err_long      (el)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i);
        return data[i*DW +: DW];
    endfunction

    // Frame-level model: collect words, judge length when TLAST or NPIX hit.
    task automatic model_step();
        bit acc;
        acc   = tvalid && m_ready;
        m_acc = acc;
        m_es  = 1'b0;
        m_el  = 1'b0;
        if (rst) begin
            m_ready  = 1'b0;
            m_valid  = 1'b0;
            m_acc    = 1'b0;
            dropping = 1'b0;
            cur.delete();
            for (int i = 0; i < NPIX; i++) exp_buf[i] = '0;
            return;
        end
        if (m_valid) begin
            if (ack) m_valid = 1'b0;
        end else if (acc) begin
            if (dropping) begin
                if (tlast) begin
                    dropping = 1'b0;
                    m_valid  = 1'b1;
                end
            end else begin
                cur.push_back(tdata);
                if (cur.size() == NPIX) begin
                    for (int i = 0; i < NPIX; i++) exp_buf[i] = cur[i];
                    cur.delete();
                    if (tlast) begin
                        m_valid = 1'b1;
                    end else begin
                        m_el     = 1'b1;
                        dropping = 1'b1;
                    end
                end else if (tlast) begin
                    m_es = 1'b1;
                    cur.delete();
                end
            end
        end
        m_ready = !m_valid;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit last, input int stall);
        int t;
        tvalid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tdata = $urandom;
            tlast = 1'($urandom_range(0, 1));
            step();
        end
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        t = 0;
        forever begin
            step();
            if (m_acc) break;
            t++;
            if (t > 200) begin
                chk("beat_timeout", 32'(m_acc), 32'd1);
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Every cycle: DUT outputs must equal the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (es === 1'b1) n_es++;
            if (el === 1'b1) n_el++;
            chk("tready", 32'(tready), 32'(m_ready));
            chk("frame_valid", 32'(fvalid), 32'(m_valid));
            chk("err_short", 32'(es), 32'(m_es));
            chk("err_long", 32'(el), 32'(m_el));
            if (m_valid) begin
                for (int i = 0; i < NPIX; i++) begin
                    chk("data", word(i), exp_buf[i]);
                end
            end
        end
    end

    initial begin
        int es0;
        int el0;
        int len;
        logic [DW-1:0] snap0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_valid", 32'(fvalid), 32'd0);
        chk("rst_data0", word(0), 32'd0);
        rst = 1'b0;
        step();
        chk("tready_rise", 32'(tready), 32'd1);

        // 1: clean frame, no stalls
        for (int b = 0; b < NPIX; b++) beat(32'h100 + DW'(b), b == NPIX - 1, 0);
        chk("t1_valid", 32'(fvalid), 32'd1);
        chk("t1_tready", 32'(tready), 32'd0);
        chk("t1_d0", word(0), 32'h100);
        chk("t1_d15", word(15), 32'h10F);
        for (int i = 0; i < 3; i++) step();
        chk("t1_hold_tready", 32'(tready), 32'd0);
        pulse_ack();

        // 2: every other cycle stalled, then one ack
        for (int b = 0; b < NPIX; b++) beat(32'h100 + DW'(b), b == NPIX - 1, 1);
        chk("t2_d7", word(7), 32'h107);
        pulse_ack();
        chk("t2_valid", 32'(fvalid), 32'd0);
        chk("t2_tready", 32'(tready), 32'd1);

        // 3: short frame then a full 0xAA frame
        es0 = n_es;
        el0 = n_el;
        for (int b = 0; b < 10; b++) beat(32'h300 + DW'(b), b == 9, 0);
        step();
        step();
        chk("t3_es_cnt", 32'(n_es - es0), 32'd1);
        chk("t3_valid", 32'(fvalid), 32'd0);
        for (int b = 0; b < NPIX; b++) beat(32'hAA, b == NPIX - 1, 0);
        for (int i = 0; i < NPIX; i++) chk("t3_word", word(i), 32'hAA);
        chk("t3_el_cnt", 32'(n_el - el0), 32'd0);
        pulse_ack();

        // 4: long frame, drained tail
        el0 = n_el;
        for (int b = 0; b < 20; b++) begin
            beat(32'h200 + DW'(b), b == 19, 0);
            if (b == 15) begin
                @(negedge clk);
                chk("t4_el_pulse", 32'(el), 32'd1);
                #1;
            end
            if (b == 18) chk("t4_valid_early", 32'(fvalid), 32'd0);
        end
        chk("t4_valid", 32'(fvalid), 32'd1);
        chk("t4_d0", word(0), 32'h200);
        chk("t4_d15", word(15), 32'h20F);
        chk("t4_el_cnt", 32'(n_el - el0), 32'd1);

        // 5: upstream pushes into a held buffer
        es0 = n_es;
        el0 = n_el;
        snap0 = word(15);
        tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tdata = $urandom;
            tlast = 1'($urandom_range(0, 1));
            step();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk("t5_tready", 32'(tready), 32'd0);
        chk("t5_d15", word(15), snap0);
        chk("t5_errs", 32'(n_es - es0 + n_el - el0), 32'd0);
        pulse_ack();

        // 6: reset mid-frame, then a full frame of 0x55
        es0 = n_es;
        el0 = n_el;
        for (int b = 0; b < 8; b++) beat(32'h400 + DW'(b), 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int b = 0; b < NPIX; b++) begin
            beat(32'h55, b == NPIX - 1, $urandom_range(0, 1));
            if (b == NPIX - 2) chk("t6_valid_early", 32'(fvalid), 32'd0);
        end
        chk("t6_valid", 32'(fvalid), 32'd1);
        chk("t6_d0", word(0), 32'h55);
        chk("t6_errs", 32'(n_es - es0 + n_el - el0), 32'd0);
        pulse_ack();

        // Random frames: lengths around NPIX, stalls, early and held acks
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 22);
            if ($urandom_range(0, 2) == 0) len = NPIX;
            ack = ($urandom_range(0, 4) == 0);
            for (int b = 0; b < len; b++) begin
                beat($urandom, b == len - 1, $urandom_range(0, 2));
            end
            if (m_valid) begin
                for (int w = $urandom_range(0, 4); w > 0; w--) step();
                pulse_ack();
            end
            ack = 1'b0;
            step();
        end

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
